seg_capture: RTL and testbench

Seven-segment readback monitor: samples the multiplexed, active-low SEGMENTS/AN display bus produced by the adder/display path and reconstructs the four hex digits being shown. It decodes each segment pattern to a nibble, with per-digit valid, blank and error flags. It sits beside the display driver as a self-check and readback block for lab benches and on-board loopback.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_decode.sv | 45 ++++
 rtl/seg_capture.sv | 202 ++++++++++++++++++++
 tb/tb_seg_capture.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment readback path.
//   - GLYPH_0..GLYPH_F : active-high gfedcba patterns for hex digits 0..F
//   - SEG_BLANK        : all segments off
//   - seg_state_e      : capture FSM states (IDLE / SETTLE / HELD)
package seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational lookup of a 7-bit active-high gfedcba pattern.
// Ports:
//   pattern  in  7  active-high segment pattern (bit 0 = a)
//   nibble   out 4  decoded hex value (0 when not a glyph)
//   is_glyph out 1  pattern is one of the 16 hex glyphs
//   is_blank out 1  pattern has all segments off
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       is_glyph,
  output logic       is_blank
);

  always_comb begin
    nibble   = 4'h0;
    is_glyph = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      GLYPH_0:   nibble = 4'h0;
      GLYPH_1:   nibble = 4'h1;
      GLYPH_2:   nibble = 4'h2;
      GLYPH_3:   nibble = 4'h3;
      GLYPH_4:   nibble = 4'h4;
      GLYPH_5:   nibble = 4'h5;
      GLYPH_6:   nibble = 4'h6;
      GLYPH_7:   nibble = 4'h7;
      GLYPH_8:   nibble = 4'h8;
      GLYPH_9:   nibble = 4'h9;
      GLYPH_A:   nibble = 4'hA;
      GLYPH_B:   nibble = 4'hB;
      GLYPH_C:   nibble = 4'hC;
      GLYPH_D:   nibble = 4'hD;
      GLYPH_E:   nibble = 4'hE;
      GLYPH_F:   nibble = 4'hF;
      SEG_BLANK: begin
        is_glyph = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_glyph = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// seg_capture: samples a multiplexed active-low seven-segment bus and
// reconstructs the four displayed hex digits with per-digit flags.
// Optional feature macro: SEG_CAPTURE_TIMEOUT_EN (per-digit staleness timeout).
// Ports:
//   CLK       in   1   system clock
//   RESET     in   1   synchronous active-high reset
//   SEGMENTS  in   7   active-low segments, bit 0 = a .. bit 6 = g (async)
//   AN        in   4   active-low anodes, AN[i] low selects digit i (async)
//   DIGITS    out 16   captured nibbles, digit i at [4i+3:4i]
//   VALID     out  4   digit holds a legal, non-stale glyph
//   BLANK     out  4   digit last committed with all segments off
//   ERR       out  4   digit last committed with an illegal pattern
//   UPDATE    out  1   one-cycle pulse per commit
//   dbg_state out  2   current capture FSM state
// Interface contract: there is no handshake; the bus is free-running and
// UPDATE is a qualifier-only strobe meaning "outputs changed this cycle".
module seg_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [6:0]  SEGMENTS,
  input  logic [3:0]  AN,
  output logic [15:0] DIGITS,
  output logic [3:0]  VALID,
  output logic [3:0]  BLANK,
  output logic [3:0]  ERR,
  output logic        UPDATE,
  output seg_state_e  dbg_state
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  // Synchronizer; all-ones is the idle (nothing driven) bus state.
  logic [10:0] sync1_q, sync1_d;
  logic [10:0] sync2_q, sync2_d;

  // Active-high view of the synchronized bus, plus the previous sample.
  logic [10:0] s;
  logic [3:0]  s_an;
  logic        one_hot;
  logic [10:0] prev_q, prev_d;

  seg_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        commit;

  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  blank_q, blank_d;
  logic [3:0]  err_q, err_d;
  logic        update_q, update_d;

  logic [3:0]  dec_nibble;
  logic        dec_glyph;
  logic        dec_blank;

  always_comb begin
    sync1_d = {AN, SEGMENTS};
    sync2_d = sync1_q;
    s       = ~sync2_q;
    s_an    = s[10:7];
    one_hot = (s_an != 4'd0) && ((s_an & (s_an - 4'd1)) == 4'd0);
    prev_d  = s;
  end

  // A commit always uses the previous sample: when the counter has reached
  // its target, prev_q is the value that stayed stable for the whole window.
  seg_decode u_decode (
    .pattern  (prev_q[6:0]),
    .nibble   (dec_nibble),
    .is_glyph (dec_glyph),
    .is_blank (dec_blank)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (one_hot) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = 8'd0;
        end
      end
      SETTLE: begin
        // The window is complete once cnt_q holds STABLE_CYCLES; the commit
        // lands on this edge even if the bus moves on at the same time.
        commit = (cnt_q == STABLE_C);
        if (!one_hot) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (s != prev_q) begin
          cnt_d   = 8'd1;
        end else if (commit) begin
          state_d = HELD;
        end else if (cnt_q != STABLE_C) begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (!one_hot) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (s != prev_q) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

`ifdef SEG_CAPTURE_TIMEOUT_EN
  localparam logic [24:0] TO_LIM = 25'(TIMEOUT_CYCLES);
  logic [24:0] to_q [4];
  logic [24:0] to_d [4];
`endif

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    err_d    = err_q;
    update_d = commit;
    for (int i = 0; i < 4; i++) begin
`ifdef SEG_CAPTURE_TIMEOUT_EN
      to_d[i] = (to_q[i] == TO_LIM) ? to_q[i] : to_q[i] + 25'd1;
      if (to_d[i] == TO_LIM) valid_d[i] = 1'b0;
`endif
      // Evaluated after the timeout so a same-edge commit wins.
      if (commit && prev_q[7+i]) begin
`ifdef SEG_CAPTURE_TIMEOUT_EN
        to_d[i] = 25'd0;
`endif
        if (dec_glyph) begin
          digits_d[4*i +: 4] = dec_nibble;
          valid_d[i] = 1'b1;
          blank_d[i] = 1'b0;
          err_d[i]   = 1'b0;
        end else if (dec_blank) begin
          valid_d[i] = 1'b0;
          blank_d[i] = 1'b1;
          err_d[i]   = 1'b0;
        end else begin
          valid_d[i] = 1'b0;
          blank_d[i] = 1'b0;
          err_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      digits_q <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      update_q <= 1'b0;
`ifdef SEG_CAPTURE_TIMEOUT_EN
      for (int i = 0; i < 4; i++) to_q[i] <= '0;
`endif
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      update_q <= update_d;
`ifdef SEG_CAPTURE_TIMEOUT_EN
      for (int i = 0; i < 4; i++) to_q[i] <= to_d[i];
`endif
    end
  end

  assign DIGITS    = digits_q;
  assign VALID     = valid_q;
  assign BLANK     = blank_q;
  assign ERR       = err_q;
  assign UPDATE    = update_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: randomized and directed stimulus on the display bus, with a
// run-length reference model predicting every commit and the flag state.
module tb_seg_capture;
  import seg_pkg::*;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 50;
`ifdef SEG_CAPTURE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_pin = 7'h7F;
  logic [3:0]  an_pin  = 4'hF;
  logic [15:0] digits;
  logic [3:0]  valid, blank, err;
  logic        update;
  seg_state_e  dbg_state;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK(clk), .RESET(rst), .SEGMENTS(seg_pin), .AN(an_pin),
    .DIGITS(digits), .VALID(valid), .BLANK(blank), .ERR(err),
    .UPDATE(update), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] m_dig [4];
  logic       m_vraw [4];
  logic       m_blank [4];
  logic       m_err [4];
  int         m_last [4];

  // Scoreboard entry: {edge[31:0], digits[15:0], valid[3:0], blank[3:0], err[3:0]}
  logic [59:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  // Current pin run: value, sample count, first capture edge.
  logic [10:0] run_val;
  int          run_len;
  int          run_start;

  function automatic logic [15:0] m_digits();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
  endfunction

  function automatic logic [3:0] m_valid_at(input int x);
    logic [3:0] v;
    for (int i = 0; i < 4; i++)
      v[i] = m_vraw[i] && (!TO_EN || (x - m_last[i]) < TIMEOUT);
    return v;
  endfunction

  function automatic logic [3:0] m_blank_v();
    return {m_blank[3], m_blank[2], m_blank[1], m_blank[0]};
  endfunction

  function automatic logic [3:0] m_err_v();
    return {m_err[3], m_err[2], m_err[1], m_err[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 4'h0; m_vraw[i] = 1'b0; m_blank[i] = 1'b0; m_err[i] = 1'b0; m_last[i] = 0;
    end
    run_val = 11'h7FF; run_len = 0; run_start = 0;
  endtask

  // A digit commits once a single-anode pin value has been seen for STABLE
  // consecutive samples; outputs change STABLE+2 edges after the first sample.
  task automatic model_commit(input logic [3:0] an, input logic [6:0] seg, input int edge_n);
    logic [3:0] sel;
    logic [6:0] pat;
    int idx;
    int found;
    sel = ~an;
    if ($countones(sel) != 1) return;
    idx = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
    pat = ~seg;
    found = -1;
    for (int k = 0; k < 16; k++) if (glyph_tab[k] == pat) found = k;
    if (found >= 0) begin
      m_dig[idx] = 4'(found); m_vraw[idx] = 1'b1; m_blank[idx] = 1'b0; m_err[idx] = 1'b0;
    end else if (pat == 7'h00) begin
      m_vraw[idx] = 1'b0; m_blank[idx] = 1'b1; m_err[idx] = 1'b0;
    end else begin
      m_vraw[idx] = 1'b0; m_blank[idx] = 1'b0; m_err[idx] = 1'b1;
    end
    m_last[idx] = edge_n;
    exp_q.push_back({32'(edge_n), m_digits(), m_valid_at(edge_n), m_blank_v(), m_err_v()});
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [3:0] an, input logic [6:0] seg, input int hold);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      an_pin  = an;
      seg_pin = seg;
      if ({an, seg} !== run_val) begin
        run_val   = {an, seg};
        run_len   = 0;
        run_start = cyc + 1;
      end
      run_len++;
      if (run_len == STABLE) model_commit(an, seg, run_start + STABLE + 2);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; an_pin = 4'hF; seg_pin = 7'h7F;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    apply(4'hF, 7'h7F, n);
  endtask

  task automatic check_now(input string name);
    logic [3:0] ev;
    @(negedge clk);
    ev = m_valid_at(cyc);
    n_vec++;
    if (digits !== m_digits() || valid !== ev || blank !== m_blank_v() ||
        err !== m_err_v() || update !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got D=%h V=%b B=%b E=%b U=%b, want D=%h V=%b B=%b E=%b U=0",
               name, digits, valid, blank, err, update, m_digits(), ev, m_blank_v(), m_err_v());
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [59:0] e;
    if (!rst) begin
      while (exp_q.size() > 0 && int'(exp_q[0][59:28]) < cyc) begin
        e = exp_q.pop_front();
        n_vec++; n_err++;
        $display("FAIL missed_commit: no UPDATE seen, want commit at edge %0d (now %0d)",
                 int'(e[59:28]), cyc);
      end
      if (update) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_update: UPDATE=1 at edge %0d, want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (int'(e[59:28]) != cyc || digits !== e[27:12] || valid !== e[11:8] ||
              blank !== e[7:4] || err !== e[3:0]) begin
            n_err++;
            $display("FAIL commit: got edge=%0d D=%h V=%b B=%b E=%b, want edge=%0d D=%h V=%b B=%b E=%b",
                     cyc, digits, valid, blank, err, int'(e[59:28]), e[27:12], e[11:8], e[7:4], e[3:0]);
          end
        end
      end
    end
  end

  // Watchdog: the bench must always end on its own.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int target;
    int guard;
    logic [3:0] an_r;
    logic [6:0] seg_r;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check_now("reset_outputs");
    n_vec++;
    if (dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d, want %0d", dbg_state, IDLE);
    end

    // Glyph 0 on digit 0.
    apply(4'b1110, ~GLYPH_0, 10);
    idle(STABLE + 4);
    check_now("digit0_glyph0");

    // Four-digit scan: 1, A, b, F.
    apply(4'b1110, ~GLYPH_1, 8);
    apply(4'b1101, ~GLYPH_A, 8);
    apply(4'b1011, ~GLYPH_B, 8);
    apply(4'b0111, ~GLYPH_F, 8);
    idle(STABLE + 4);
    check_now("scan_four");
    n_vec++;
    if (digits !== 16'hFBA1 || valid !== 4'b1111) begin
      n_err++;
      $display("FAIL scan_literal: got D=%h V=%b, want D=fba1 V=1111", digits, valid);
    end

    // Short glitch to blank must not commit.
    apply(4'b1110, ~GLYPH_8, 8);
    apply(4'b1110, 7'h7F, 2);
    apply(4'b1110, ~GLYPH_8, 8);
    idle(STABLE + 4);
    check_now("glitch_rejected");

    // Two anodes active: nothing commits.
    apply(4'b1100, ~GLYPH_3, 20);
    idle(STABLE + 4);
    check_now("two_anodes");

    // Non-glyph pattern on digit 2.
    apply(4'b1011, 7'h7E, 8);
    idle(STABLE + 4);
    check_now("err_digit2");

    // Blank commit on digit 1.
    apply(4'b1101, 7'h7F, 8);
    idle(STABLE + 4);
    check_now("blank_digit1");

    // Same digit re-displayed after an anode change commits again.
    apply(4'b0111, ~GLYPH_7, 6);
    apply(4'b1111, 7'h7F, 2);
    apply(4'b0111, ~GLYPH_7, 6);
    idle(STABLE + 4);
    check_now("redisplay");

    // Reset mid-settle aborts; the window restarts from post-reset samples.
    apply(4'b1110, ~GLYPH_9, 3);
    do_reset();
    check_now("reset_mid_settle");
    apply(4'b1110, ~GLYPH_9, STABLE - 1);
    idle(STABLE + 4);
    check_now("post_reset_short");
    apply(4'b1110, ~GLYPH_9, STABLE + 6);
    idle(STABLE + 4);
    check_now("post_reset_commit");

    // Timeout behaviour on digit 0.
    apply(4'b1110, ~GLYPH_5, 6);
    idle(1);
    target = m_last[0] + TIMEOUT - 1;
    guard = 0;
    while (cyc < target && guard < 10000) begin
      @(negedge clk); guard++;
    end
    n_vec++;
    if (valid[0] !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_before: got VALID[0]=%b, want 1", valid[0]);
    end
    @(negedge clk);
    n_vec++;
    if (valid[0] !== m_valid_at(cyc)[0] || valid[0] !== (TO_EN ? 1'b0 : 1'b1) || digits[3:0] !== 4'h5) begin
      n_err++;
      $display("FAIL timeout_edge: got VALID[0]=%b D0=%h, want VALID[0]=%b D0=5",
               valid[0], digits[3:0], TO_EN ? 1'b0 : 1'b1);
    end
    idle(2);

    // Randomized bus activity.
    for (int p = 0; p < 120; p++) begin
      case ($urandom_range(0, 9))
        0:       an_r = 4'hF;
        1:       an_r = 4'($urandom_range(0, 15));
        default: an_r = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 9))
        0:       seg_r = 7'h7F;
        1:       seg_r = 7'($urandom_range(0, 127));
        default: seg_r = ~glyph_tab[$urandom_range(0, 15)];
      endcase
      apply(an_r, seg_r, $urandom_range(1, 8));
    end
    idle(STABLE + 4);
    check_now("random_final");

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_commits: got %0d unobserved, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
